sound_dac_serializer: RTL



---
 rtl/sound_dac_serializer_pkg.sv | 17 +
 rtl/sound_dac_serializer_if.sv | 18 +
 rtl/sound_dac_serializer_sample_hold_reg.sv | 40 ++++
 rtl/sound_dac_serializer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sound_dac_serializer_pkg.sv
// Shared types and default framing constants for the sound DAC serializer.
// Holds the FSM state encoding and the default frame geometry.
package sound_dac_serializer_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int FRAME_BITS_DEF = 16;
    localparam int LEAD_ZEROS_DEF = 2;
    localparam int SYNC_IDLE_DEF  = 2;
    localparam int OVR_W_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } dac_state_t;

endpackage

// File: rtl/sound_dac_serializer_if.sv
// Sample strobe bus from the sound core into the DAC serializer.
// master drives sample_valid/sample_data, slave receives them.
interface sound_dac_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_valid;
    logic [DATA_BITS-1:0] sample_data;

    modport master (
        output sample_valid,
        output sample_data
    );

    modport slave (
        input sample_valid,
        input sample_data
    );
endinterface

// File: rtl/sound_dac_serializer_sample_hold_reg.sv
// One-entry overwrite buffer between sample strobes and the frame shifter.
// Ports: clk, rst, load/load_data in, consume in, full/data out, overrun_count out.
module sample_hold_reg #(
    parameter int DATA_BITS = 8,
    parameter int OVR_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 consume,
    output logic                 full,
    output logic [DATA_BITS-1:0] data,
    output logic [OVR_W-1:0]     overrun_count
);

    // A load onto a full entry that the shifter is not taking this edge
    // discards the older sample.
    logic overrun;
    assign overrun = load && full && !consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full          <= 1'b0;
            data          <= '0;
            overrun_count <= '0;
        end else begin
            if (load) begin
                data <= load_data;
                full <= 1'b1;
            end else if (consume) begin
                full <= 1'b0;
            end
            if (overrun && (overrun_count != '1)) begin
                overrun_count <= overrun_count + OVR_W'(1);
            end
        end
    end

endmodule

// File: rtl/sound_dac_serializer.sv
// Serializes 8-bit sound samples into 16-bit SYNC_n-framed DAC words, MSB first.
// Ports: clk, rst, smp (slave: sample_valid/sample_data), dac_sync_n, dac_sdin,
//        busy, frame_done, overrun_count.
module sound_dac_serializer
    import sound_dac_serializer_pkg::*;
#(
    parameter int DATA_BITS        = DATA_BITS_DEF,
    parameter int FRAME_BITS       = FRAME_BITS_DEF,
    parameter int LEAD_ZEROS       = LEAD_ZEROS_DEF,
    parameter int SYNC_IDLE_CYCLES = SYNC_IDLE_DEF,
    parameter int OVR_W            = OVR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    sound_dac_serializer_if.slave smp,
    output logic                  dac_sync_n,
    output logic                  dac_sdin,
    output logic                  busy,
    output logic                  frame_done,
    output logic [OVR_W-1:0]      overrun_count
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int GAP_W = $clog2(SYNC_IDLE_CYCLES + 1);

    dac_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [FRAME_BITS-1:0] frame_w;
    logic                  sync_n_d, sdin_d, done_d;
    logic                  consume;
    logic                  hold_full;
    logic [DATA_BITS-1:0]  hold_data;

    sample_hold_reg #(
        .DATA_BITS (DATA_BITS),
        .OVR_W     (OVR_W)
    ) u_hold (
        .clk           (clk),
        .rst           (rst),
        .load          (smp.sample_valid),
        .load_data     (smp.sample_data),
        .consume       (consume),
        .full          (hold_full),
        .data          (hold_data),
        .overrun_count (overrun_count)
    );

    always_comb begin
        frame_w = '0;
        frame_w[FRAME_BITS-1-LEAD_ZEROS -: DATA_BITS] = hold_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            shreg_q    <= '0;
            dac_sync_n <= 1'b1;
            dac_sdin   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            shreg_q    <= shreg_d;
            dac_sync_n <= sync_n_d;
            dac_sdin   <= sdin_d;
            frame_done <= done_d;
        end
    end

    // cnt_q counts bits already on the pin; gap_q counts sync-high cycles
    // starting with the frame_done cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        shreg_d  = shreg_q;
        sync_n_d = dac_sync_n;
        sdin_d   = dac_sdin;
        done_d   = 1'b0;
        consume  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hold_full) begin
                    consume  = 1'b1;
                    state_d  = ST_SHIFT;
                    sync_n_d = 1'b0;
                    sdin_d   = frame_w[FRAME_BITS-1];
                    shreg_d  = {frame_w[FRAME_BITS-2:0], 1'b0};
                    cnt_d    = CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(FRAME_BITS)) begin
                    state_d  = ST_GAP;
                    sync_n_d = 1'b1;
                    sdin_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    gap_d    = GAP_W'(1);
                end else begin
                    sdin_d  = shreg_q[FRAME_BITS-1];
                    shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q >= GAP_W'(SYNC_IDLE_CYCLES)) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE) || hold_full;

endmodule
